// File: rtl/pl_pkg.sv
// Shared types, field masks and range helper for the RV32I immediate encoder.
// Masks select the instruction bits that each immediate format overwrites.
package pl_pkg;

  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    IMM_I   = 3'b000,
    IMM_S   = 3'b001,
    IMM_B   = 3'b010,
    IMM_U   = 3'b011,
    IMM_J   = 3'b100,
    IMM_UNS = 3'b101
  } imm_src_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FULL = 2'b10
  } enc_state_t;

  localparam logic [XLEN-1:0] MASK_I = 32'hFFF0_0000;
  localparam logic [XLEN-1:0] MASK_S = 32'hFE00_0F80;
  localparam logic [XLEN-1:0] MASK_B = 32'hFE00_0F80;
  localparam logic [XLEN-1:0] MASK_U = 32'hFFFF_F000;
  localparam logic [XLEN-1:0] MASK_J = 32'hFFFF_F000;

  // True when the bits selected by upper are all ones or all zeros (value fits after sign extension).
  function automatic logic is_sext(input logic [XLEN-1:0] v, input logic [XLEN-1:0] upper);
    return ((v & upper) == upper) || ((v & upper) == 32'd0);
  endfunction

endpackage

// File: rtl/pl_imm_pack.sv
// Combinational scatter of an immediate into its instruction-word field,
// plus a legality flag saying whether the value survives the round trip.
module pl_imm_pack
  import pl_pkg::*;
(
  input  logic [2:0]      imm_src,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] base_instr,
  output logic [XLEN-1:0] instr,
  output logic            legal
);

  logic [XLEN-1:0] mask_s;
  logic [XLEN-1:0] field_s;

  // Select mask/field per format; codes 110/111 fall back to the I layout but are flagged.
  always_comb begin
    mask_s  = MASK_I;
    field_s = {imm[11:0], 20'd0};
    legal   = 1'b0;
    case (imm_src)
      IMM_I: begin
        mask_s  = MASK_I;
        field_s = {imm[11:0], 20'd0};
        legal   = is_sext(imm, 32'hFFFF_F800);
      end
      IMM_S: begin
        mask_s  = MASK_S;
        field_s = {imm[11:5], 13'd0, imm[4:0], 7'd0};
        legal   = is_sext(imm, 32'hFFFF_F800);
      end
      IMM_B: begin
        mask_s  = MASK_B;
        field_s = {imm[12], imm[10:5], 13'd0, imm[4:1], imm[11], 7'd0};
        legal   = is_sext(imm, 32'hFFFF_F000) && (imm[0] == 1'b0);
      end
      IMM_U: begin
        mask_s  = MASK_U;
        field_s = {imm[31:12], 12'd0};
        legal   = (imm[11:0] == 12'd0);
      end
      IMM_J: begin
        mask_s  = MASK_J;
        field_s = {imm[20], imm[10:1], imm[11], imm[19:12], 12'd0};
        legal   = is_sext(imm, 32'hFFF0_0000) && (imm[0] == 1'b0);
      end
      IMM_UNS: begin
        mask_s  = MASK_I;
        field_s = {imm[11:0], 20'd0};
        legal   = (imm[31:12] == 20'd0);
      end
      default: begin
        mask_s  = MASK_I;
        field_s = {imm[11:0], 20'd0};
        legal   = 1'b0;
      end
    endcase
    instr = (base_instr & ~mask_s) | field_s;
  end

endmodule

// File: rtl/pl_imm_encoder.sv
// Immediate encoder front end: accepts encode requests, registers one word
// and streams it to instruction memory at consecutive addresses until full.
module pl_imm_encoder
  import pl_pkg::*;
#(
  parameter int W     = 32,
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    imm_src,
  input  logic [W-1:0]  imm,
  input  logic [W-1:0]  base_instr,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_addr,
  output logic [W-1:0]  out_instr,
  output logic          range_err,
  output logic          full
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  enc_state_t    state_q, state_d;
  logic          out_valid_q, out_valid_d;
  logic [AW-1:0] out_addr_q, out_addr_d;
  logic [W-1:0]  out_instr_q, out_instr_d;
  logic          full_q, full_d;
  logic          range_err_q, range_err_d;

  logic          wr_hs_s;
  logic          last_wr_s;
  logic          accept_s;
  logic          legal_s;
  logic [W-1:0]  packed_s;

  pl_imm_pack u_pack (
    .imm_src    (imm_src),
    .imm        (imm),
    .base_instr (base_instr),
    .instr      (packed_s),
    .legal      (legal_s)
  );

  assign wr_hs_s   = out_valid_q && out_ready;
  assign last_wr_s = wr_hs_s && (out_addr_q == LAST_ADDR);
  // The final write blocks acceptance so nothing is captured that could never be written.
  assign in_ready  = (state_q == RUN) && (!out_valid_q || out_ready) && !last_wr_s;
  assign accept_s  = in_valid && in_ready;

  // Next-state logic; start overrides any same-cycle handshake or accept.
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_addr_d  = out_addr_q;
    out_instr_d = out_instr_q;
    full_d      = full_q;
    range_err_d = range_err_q;
    if (start) begin
      state_d     = RUN;
      out_valid_d = 1'b0;
      out_addr_d  = '0;
      full_d      = 1'b0;
      range_err_d = 1'b0;
    end else begin
      if (wr_hs_s) begin
        out_valid_d = 1'b0;
        if (last_wr_s) begin
          out_addr_d = '0;
          full_d     = 1'b1;
          state_d    = FULL;
        end else begin
          out_addr_d = out_addr_q + 1'b1;
        end
      end else begin
        out_addr_d = out_addr_q;
      end
      if (accept_s) begin
        out_valid_d = 1'b1;
        out_instr_d = packed_s;
        if (!legal_s) begin
          range_err_d = 1'b1;
        end else begin
          range_err_d = range_err_q;
        end
      end else begin
        out_instr_d = out_instr_q;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_instr_q <= '0;
      full_q      <= 1'b0;
      range_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_addr_q  <= out_addr_d;
      out_instr_q <= out_instr_d;
      full_q      <= full_d;
      range_err_q <= range_err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_addr  = out_addr_q;
  assign out_instr = out_instr_q;
  assign full      = full_q;
  assign range_err = range_err_q;

endmodule

// File: tb/tb_pl_imm_encoder.sv
// Directed bench for pl_imm_encoder: requests push expected writes to a
// scoreboard that a write monitor pops and compares on every memory handshake.
module tb_pl_imm_encoder;

  localparam int W     = 32;
  localparam int DEPTH = 256;
  localparam int AW    = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b1;
  logic [2:0]    imm_src = 3'b000;
  logic [W-1:0]  imm = 32'd0;
  logic [W-1:0]  base_instr = 32'd0;
  logic          in_ready;
  logic          out_valid;
  logic [AW-1:0] out_addr;
  logic [W-1:0]  out_instr;
  logic          range_err;
  logic          full;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [W-1:0]  instr;
  } wr_t;

  wr_t           sb[$];
  wr_t           mon_e;
  logic [AW-1:0] exp_addr = 8'd0;
  int            errors = 0;
  int            checks = 0;
  int            writes = 0;
  int            w0;

  always #5 clk = ~clk;

  pl_imm_encoder #(.W(W), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .imm_src    (imm_src),
    .imm        (imm),
    .base_instr (base_instr),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_addr   (out_addr),
    .out_instr  (out_instr),
    .range_err  (range_err),
    .full       (full)
  );

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [2:0] s, input logic [W-1:0] v, input logic [W-1:0] b,
                      input logic [W-1:0] exp);
    int n;
    n = 0;
    imm_src = s;
    imm = v;
    base_instr = b;
    in_valid = 1'b1;
    #1;
    while (!in_ready && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("send_ready", 32'(in_ready), 32'd1);
    if (in_ready) begin
      sb.push_back(wr_t'{exp_addr, exp});
      exp_addr = exp_addr + 8'd1;
    end else begin
      in_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    sb.delete();
    exp_addr = 8'd0;
  endtask

  // Write monitor: every memory handshake must match the oldest expected write.
  always @(negedge clk) begin
    if (rst_n && !start && out_valid && out_ready) begin
      writes++;
      chk("wr_expected", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        chk("wr_addr", 32'(out_addr), 32'(mon_e.addr));
        chk("wr_instr", out_instr, mon_e.instr);
      end
    end
  end

  initial begin
    #3;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_addr", 32'(out_addr), 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_range_err", 32'(range_err), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick(1);
    chk("idle_in_ready", 32'(in_ready), 32'd0);

    do_start();
    send(3'b000, 32'hFFFF_FFFF, 32'h0000_0013, 32'hFFF0_0013);
    tick(1);
    chk("i_range_err", 32'(range_err), 32'd0);
    send(3'b001, 32'hFFFF_FFF8, 32'h0000_2023, 32'hFE00_2C23);
    send(3'b010, 32'hFFFF_FFFC, 32'h0000_0063, 32'hFE00_0EE3);
    send(3'b100, 32'h0000_0008, 32'h0000_006F, 32'h0080_006F);
    send(3'b011, 32'h1234_5000, 32'h0000_0037, 32'h1234_5037);
    send(3'b101, 32'h0000_0FFF, 32'h0000_0013, 32'hFFF0_0013);
    tick(2);
    chk("legal_range_err", 32'(range_err), 32'd0);

    // Out-of-range I immediate still writes its truncated field.
    send(3'b000, 32'h0000_0800, 32'h0000_0013, 32'h8000_0013);
    tick(1);
    chk("err_set", 32'(range_err), 32'd1);
    send(3'b000, 32'h0000_0001, 32'h0000_0013, 32'h0010_0013);
    tick(3);
    chk("err_held", 32'(range_err), 32'd1);
    send(3'b110, 32'h0000_0002, 32'h0000_0013, 32'h0020_0013);
    tick(2);
    do_start();
    chk("err_cleared", 32'(range_err), 32'd0);
    chk("start_addr", 32'(out_addr), 32'd0);

    // Back-pressure: pending word holds stable, then exactly one write.
    out_ready = 1'b0;
    send(3'b000, 32'h0000_0005, 32'h0000_0013, 32'h0050_0013);
    for (int k = 0; k < 5; k++) begin
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_instr", out_instr, 32'h0050_0013);
      chk("stall_addr", 32'(out_addr), 32'd0);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      tick(1);
    end
    w0 = writes;
    out_ready = 1'b1;
    tick(1);
    chk("release_writes", 32'(writes - w0), 32'd1);
    chk("release_addr", 32'(out_addr), 32'd1);
    chk("release_valid", 32'(out_valid), 32'd0);

    // Stream DEPTH words back to back.
    do_start();
    w0 = writes;
    imm_src = 3'b000;
    base_instr = 32'h0000_0013;
    in_valid = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      imm = 32'(i);
      #1;
      chk("stream_ready", 32'(in_ready), 32'd1);
      sb.push_back(wr_t'{exp_addr, (32'(i) << 20) | 32'h0000_0013});
      exp_addr = exp_addr + 8'd1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    tick(1);
    chk("stream_writes", 32'(writes - w0), 32'(DEPTH));
    chk("full_set", 32'(full), 32'd1);
    chk("full_addr_wrap", 32'(out_addr), 32'd0);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_valid", 32'(out_valid), 32'd0);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    in_valid = 1'b1;
    tick(3);
    chk("full_ignores_in", 32'(out_valid), 32'd0);
    in_valid = 1'b0;
    do_start();
    chk("restart_full", 32'(full), 32'd0);
    chk("restart_ready", 32'(in_ready), 32'd1);

    // Asynchronous reset between edges with a word pending.
    send(3'b000, 32'h0000_0003, 32'h0000_0013, 32'h0030_0013);
    tick(1);
    out_ready = 1'b0;
    send(3'b000, 32'h0000_0007, 32'h0000_0013, 32'h0070_0013);
    chk("pre_rst_addr", 32'(out_addr), 32'd1);
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_addr", 32'(out_addr), 32'd0);
    chk("arst_instr", out_instr, 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd0);
    sb.delete();
    exp_addr = 8'd0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick(1);
    chk("post_rst_idle", 32'(in_ready), 32'd0);

    // start wins over a same-cycle accept.
    do_start();
    w0 = writes;
    imm_src = 3'b000;
    imm = 32'h0000_0009;
    base_instr = 32'h0000_0013;
    start = 1'b1;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    in_valid = 1'b0;
    chk("start_drop_valid", 32'(out_valid), 32'd0);
    tick(2);
    chk("start_drop_writes", 32'(writes - w0), 32'd0);
    chk("start_drop_addr", 32'(out_addr), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
